// File: rtl/spi_frame_decoder_if.sv
// spi_frame_decoder_if: command handshake from the frame decoder to the register/control logic.
interface spi_frame_decoder_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_addr;
  logic [23:0] cmd_data;
  modport master (output cmd_valid, cmd_op, cmd_addr, cmd_data, input cmd_ready);
  modport slave (input cmd_valid, cmd_op, cmd_addr, cmd_data, output cmd_ready);
endinterface

// File: rtl/spi_frame_decoder.sv
// spi_frame_decoder: captures the SPI word at ss_n rising and issues one command per frame.
// Define SPI_PARITY_CHECK_EN to also reject words with odd overall parity.
module spi_frame_decoder #(
  parameter int FCNT_W = 8,
  parameter int ECNT_W = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  ss_n,
  input  logic [31:0]           spi_word,
  input  logic                  overrun_clr,
  spi_frame_decoder_if.master   cmd,
  output logic                  frame_error,
  output logic                  overrun,
  output logic [FCNT_W-1:0]     frame_count,
  output logic [ECNT_W-1:0]     error_count,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, CAPTURE, CHECK, ISSUE} state_t;
  state_t      state, state_nx;
  logic [2:0]  ss_sync;
  logic [31:0] word_q;
  logic [1:0]  op_q;
  logic [5:0]  addr_q;
  logic [23:0] data_q;
  logic        frame_end, bad, valid;
  assign frame_end = ss_sync[2:1] == 2'b01;
`ifdef SPI_PARITY_CHECK_EN
  assign bad = (&word_q[31:30]) | (^word_q);
`else
  assign bad = &word_q[31:30];
`endif
  assign cmd.cmd_valid = valid;
  assign cmd.cmd_op    = op_q;
  assign cmd.cmd_addr  = addr_q;
  assign cmd.cmd_data  = data_q;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE    ? (frame_end ? CAPTURE : IDLE) :
               state == CAPTURE ? CHECK :
               state == CHECK   ? (bad ? IDLE : ISSUE) :
                                  (cmd.cmd_ready ? IDLE : ISSUE);
    valid    = state == ISSUE;
    busy     = state != IDLE;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      ss_sync     <= 3'b111;
      word_q      <= '0;
      op_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= '0;
      error_count <= '0;
    end else begin
      ss_sync     <= {ss_sync[1:0], ss_n};
      frame_error <= state == CHECK && bad;
      // a frame ending while one is still in flight is dropped; set beats clear
      overrun     <= (frame_end && state != IDLE) | (overrun & ~overrun_clr);
      if (state == CAPTURE) word_q <= spi_word;
      if (state == CHECK && !bad) begin
        op_q        <= word_q[31:30];
        addr_q      <= word_q[29:24];
        data_q      <= word_q[23:0];
        frame_count <= frame_count + FCNT_W'(1);
      end
      if (state == CHECK && bad && !(&error_count)) error_count <= error_count + ECNT_W'(1);
    end
endmodule

// File: tb/tb_spi_frame_decoder.sv
// tb_spi_frame_decoder: directed frames with hand-computed expectations for spi_frame_decoder.
module tb_spi_frame_decoder;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ss_n = 1'b1;
  logic [31:0] spi_word = '0;
  logic        overrun_clr = 1'b0;
  logic        frame_error, overrun, busy;
  logic [7:0]  frame_count;
  logic [3:0]  error_count;
  int          n_chk = 0;
  int          n_pass = 0;
  logic        seen;
  spi_frame_decoder_if cmd_if ();
  spi_frame_decoder dut (
    .clock(clock), .reset_n(reset_n), .ss_n(ss_n), .spi_word(spi_word),
    .overrun_clr(overrun_clr), .cmd(cmd_if), .frame_error(frame_error),
    .overrun(overrun), .frame_count(frame_count), .error_count(error_count), .busy(busy)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic wait_n(input int n);
    repeat (n) @(negedge clock);
  endtask
  // ss_n low for two clocks then high; frame_end follows two edges later, cmd_valid five
  task automatic send(input logic [31:0] w);
    @(negedge clock);
    spi_word = w;
    ss_n = 1'b0;
    wait_n(2);
    ss_n = 1'b1;
  endtask
  initial begin
    cmd_if.cmd_ready = 1'b1;
    wait_n(3);
    reset_n = 1'b1;
    check("rst_valid", cmd_if.cmd_valid, 0);
    check("rst_fields", {cmd_if.cmd_op, cmd_if.cmd_addr, cmd_if.cmd_data}, 0);
    check("rst_status", {frame_error, overrun, busy}, 0);
    check("rst_counts", {frame_count, error_count}, 0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clock);
      seen |= frame_error | busy;
    end
    check("idle_quiet", seen, 0);
    send(32'h0A12_3456);
    wait_n(4);
    check("wr_n2_valid", cmd_if.cmd_valid, 0);
    check("wr_n2_busy", busy, 1);
    wait_n(1);
    check("wr_n3_valid", cmd_if.cmd_valid, 1);
    check("wr_op", cmd_if.cmd_op, 2'b00);
    check("wr_addr", cmd_if.cmd_addr, 6'h0A);
    check("wr_data", cmd_if.cmd_data, 24'h123456);
    check("wr_fcnt", frame_count, 1);
    wait_n(1);
    check("wr_n4_valid", cmd_if.cmd_valid, 0);
    check("wr_n4_busy", busy, 0);
    send(32'hC000_0001);
    wait_n(4);
    check("rsv_n2_ferr", frame_error, 0);
    wait_n(1);
    check("rsv_ferr", frame_error, 1);
    check("rsv_ecnt", error_count, 1);
    check("rsv_valid", cmd_if.cmd_valid, 0);
    wait_n(1);
    check("rsv_ferr_pulse", frame_error, 0);
    check("rsv_fcnt", frame_count, 1);
    cmd_if.cmd_ready = 1'b0;
    send(32'h4100_0000);
    wait_n(5);
    check("rd_valid", cmd_if.cmd_valid, 1);
    check("rd_fields", {cmd_if.cmd_op, cmd_if.cmd_addr, cmd_if.cmd_data}, 32'h4100_0000);
    check("rd_fcnt", frame_count, 2);
    check("rd_no_ovr", overrun, 0);
    send(32'h0A00_0005);
    wait_n(3);
    check("ovr_set", overrun, 1);
    check("ovr_hold_fields", {cmd_if.cmd_op, cmd_if.cmd_addr, cmd_if.cmd_data}, 32'h4100_0000);
    check("ovr_fcnt", frame_count, 2);
    wait_n(5);
    check("hold_valid", cmd_if.cmd_valid, 1);
    cmd_if.cmd_ready = 1'b1;
    wait_n(1);
    check("rd_done", cmd_if.cmd_valid, 0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clock);
      seen |= cmd_if.cmd_valid;
    end
    check("ovr_one_cmd", seen, 0);
    check("ovr_sticky", overrun, 1);
    overrun_clr = 1'b1;
    wait_n(1);
    overrun_clr = 1'b0;
    check("ovr_clr", overrun, 0);
    for (int i = 0; i < 20; i++) begin
      send(32'hC000_0000 | i);
      wait_n(6);
    end
    check("ecnt_sat", error_count, 4'hF);
    check("ecnt_fcnt", frame_count, 2);
    send(32'h8000_0000);
    wait_n(3);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_counts", {frame_count, error_count}, 0);
    wait_n(2);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clock);
      seen |= cmd_if.cmd_valid | busy | frame_error;
    end
    check("midrst_quiet", seen, 0);
    for (int i = 0; i < 300; i++) begin
      send({2'(i % 3), 6'(i), 24'(i)});
      wait_n(6);
    end
    check("fcnt_wrap", frame_count, 8'd44);
    check("fcnt_last", {cmd_if.cmd_op, cmd_if.cmd_addr, cmd_if.cmd_data}, {2'd2, 6'd43, 24'd299});
    check("fcnt_ecnt", error_count, 0);
`ifdef SPI_PARITY_CHECK_EN
    send(32'h0000_0001);
    wait_n(5);
    check("par_odd_ferr", frame_error, 1);
    check("par_odd_valid", cmd_if.cmd_valid, 0);
    check("par_odd_ecnt", error_count, 1);
    send(32'h0000_0003);
    wait_n(5);
    check("par_even_valid", cmd_if.cmd_valid, 1);
    check("par_even_data", cmd_if.cmd_data, 24'h000003);
`else
    send(32'h0000_0001);
    wait_n(5);
    check("nopar_valid", cmd_if.cmd_valid, 1);
    check("nopar_data", cmd_if.cmd_data, 24'h000001);
    check("nopar_ecnt", error_count, 0);
`endif
    wait_n(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
